// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller: per-channel idle hold-off, wake handshake, latch+AND gate.
// Latency: gate closes HOLDOFF edges after idle is sampled; reopens one pulse after wake, CH_RDY after WAKE_CYC+1.
// Backpressure: none; CH_RDY low tells the consumer its clock is not yet usable. Option macro: CLK_GATE_SCAN_BYPASS_EN.
module clk_gate_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int HOLDOFF  = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] AUTO_EN,
    input  logic [NUM_CH-1:0] CH_BUSY,
`ifdef CLK_GATE_SCAN_BYPASS_EN
    input  logic              TEST_EN,
`endif
    output logic [NUM_CH-1:0] GATED_CLK,
    output logic [NUM_CH-1:0] CH_RDY,
    output logic              ALL_OFF
);

    // Counter only needs to hold the larger of the two load values.
    localparam int MAX_CYC = (HOLDOFF > WAKE_CYC) ? HOLDOFF : WAKE_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);
    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYC - 1);
    localparam logic [CW-1:0] CNT_ZERO  = '0;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_HOLD = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } state_t;

    logic [NUM_CH-1:0] is_off;
    logic              all_off_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          en_q, en_d;
        logic          rdy_q, rdy_d;
        logic          gate_in;
        logic          en_lat_q;

        // Channel state, counter, gate enable and ready flag; reset opens the clock.
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                state_q <= ST_ON;
                cnt_q   <= CNT_ZERO;
                en_q    <= 1'b1;
                rdy_q   <= 1'b1;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                en_q    <= en_d;
                rdy_q   <= rdy_d;
            end
        end

        // Next-state logic; counts load or decrement toward zero and never wrap.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_ON: begin
                    // A simultaneous busy drop and auto-enable drop keeps the channel on.
                    if (AUTO_EN[g] && !CH_BUSY[g]) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (CH_BUSY[g] || !AUTO_EN[g]) begin
                        state_d = ST_ON;
                    end else if (cnt_q == CNT_ZERO) begin
                        state_d = ST_OFF;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_OFF: begin
                    if (CH_BUSY[g] || !AUTO_EN[g]) begin
                        state_d = ST_WAKE;
                        cnt_d   = WAKE_LOAD;
                    end
                end
                ST_WAKE: begin
                    // Activity is ignored here so a wake always completes.
                    if (cnt_q == CNT_ZERO) begin
                        state_d = ST_ON;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_ON;
                    cnt_d   = CNT_ZERO;
                end
            endcase
            en_d  = (state_d != ST_OFF);
            rdy_d = (state_d == ST_ON) || (state_d == ST_HOLD);
        end

`ifdef CLK_GATE_SCAN_BYPASS_EN
        assign gate_in   = en_q | TEST_EN;
        assign CH_RDY[g] = rdy_q | TEST_EN;
`else
        assign gate_in   = en_q;
        assign CH_RDY[g] = rdy_q;
`endif

        // Gate latch is transparent only while CLK is low, so the AND output cannot glitch.
        always_latch begin
            if (!CLK) begin
                en_lat_q <= gate_in;
            end
        end

        assign GATED_CLK[g] = CLK & en_lat_q;
        assign is_off[g]    = (state_q == ST_OFF);
    end

    // Registered all-channels-off flag, one edge behind the channel states.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            all_off_q <= 1'b0;
        end else begin
            all_off_q <= &is_off;
        end
    end

    assign ALL_OFF = all_off_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with NUM_CH=4, HOLDOFF=4, WAKE_CYC=2.
// Inputs change 1 ns after a rising edge and are sampled at the next one; GATED_CLK read
// 1 ns after a rising edge shows whether that edge produced a gated pulse.
module tb_clk_gate_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] auto_en;
    logic [3:0] ch_busy;
    logic       test_en;
    logic [3:0] gated_clk;
    logic [3:0] ch_rdy;
    logic       all_off;

    int n_chk;
    int n_err;

    clk_gate_ctrl #(
        .NUM_CH   (4),
        .HOLDOFF  (4),
        .WAKE_CYC (2)
    ) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .AUTO_EN   (auto_en),
        .CH_BUSY   (ch_busy),
`ifdef CLK_GATE_SCAN_BYPASS_EN
        .TEST_EN   (test_en),
`endif
        .GATED_CLK (gated_clk),
        .CH_RDY    (ch_rdy),
        .ALL_OFF   (all_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        auto_en = 4'h0;
        ch_busy = 4'h0;
        test_en = 1'b0;

        // Reset: every clock open, ready high, not all-off.
        tick();
        tick();
        chk("rst_pulse", gated_clk, 4'hF);
        chk("rst_rdy", ch_rdy, 4'hF);
        chk("rst_alloff", all_off, 1'b0);
        rst_n = 1'b1;

        // Auto-gating disabled: clocks keep running.
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("noauto_pulse", gated_clk, 4'hF);
            chk("noauto_rdy", ch_rdy, 4'hF);
            chk("noauto_alloff", all_off, 1'b0);
        end

        // ch0 idle sampled at edge 1: pulses through edge 5, gated from edge 6.
        auto_en = 4'h1;
        ch_busy = 4'h0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("idle_pulse", gated_clk, (i <= 5) ? 4'hF : 4'hE);
            chk("idle_rdy", ch_rdy, (i <= 4) ? 4'hF : 4'hE);
        end
        chk("idle_alloff", all_off, 1'b0);

        // Wake: request sampled at edge 1, first pulse at edge 2, ready after edge 3.
        ch_busy = 4'h1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("wake_pulse", gated_clk, (i == 1) ? 4'hE : 4'hF);
            chk("wake_rdy", ch_rdy, (i <= 2) ? 4'hE : 4'hF);
        end

        // Idle 3, busy 1, then idle: count restarts, so gating lands at edge 9.
        for (int i = 1; i <= 10; i++) begin
            ch_busy = (i == 4) ? 4'h1 : 4'h0;
            tick();
            chk("restart_pulse", gated_clk, (i <= 9) ? 4'hF : 4'hE);
            chk("restart_rdy", ch_rdy, (i <= 8) ? 4'hF : 4'hE);
        end

        // Auto-enable low wakes an OFF channel; dropping it mid-hold abandons the count.
        ch_busy = 4'h0;
        for (int i = 1; i <= 12; i++) begin
            auto_en = (i <= 3 || i == 6) ? 4'h0 : 4'h1;
            tick();
            chk("abandon_pulse", gated_clk, (i == 1 || i == 12) ? 4'hE : 4'hF);
            chk("abandon_rdy", ch_rdy, (i <= 2 || i >= 11) ? 4'hE : 4'hF);
        end

        // All channels idle: ch1..3 enter OFF at edge 5, ALL_OFF follows at edge 6.
        auto_en = 4'hF;
        ch_busy = 4'h0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("alloff_flag", all_off, (i == 6) ? 1'b1 : 1'b0);
            chk("alloff_pulse", gated_clk, (i <= 5) ? 4'hE : 4'h0);
            chk("alloff_rdy", ch_rdy, (i <= 4) ? 4'hE : 4'h0);
        end

        // Reset mid-OFF: ready and flag clear at once, clocks run from the next pulse.
        rst_n = 1'b0;
        #1;
        chk("midrst_rdy", ch_rdy, 4'hF);
        chk("midrst_alloff", all_off, 1'b0);
        tick();
        chk("midrst_pulse", gated_clk, 4'hF);
        rst_n = 1'b1;
        tick();
        chk("postrst_pulse", gated_clk, 4'hF);
        chk("postrst_rdy", ch_rdy, 4'hF);

`ifdef CLK_GATE_SCAN_BYPASS_EN
        // Let everything gate off again, then force the clocks open with the bypass.
        for (int i = 1; i <= 8; i++) begin
            tick();
        end
        chk("scan_pre_alloff", all_off, 1'b1);
        chk("scan_pre_pulse", gated_clk, 4'h0);
        test_en = 1'b1;
        #1;
        chk("scan_rdy", ch_rdy, 4'hF);
        tick();
        chk("scan_pulse", gated_clk, 4'hF);
        chk("scan_alloff", all_off, 1'b1);
        test_en = 1'b0;
        tick();
        chk("scan_off_pulse", gated_clk, 4'h0);
        chk("scan_off_rdy", ch_rdy, 4'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
